tx_fifo_feeder: RTL and testbench
=================================

TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

Interface
REQ-001 Parameter DBIT, default 8, data width in bits per byte.
REQ-002 Parameter ADDR_BITS, default 4, FIFO address width; DEPTH = 2^ADDR_BITS entries (16).
REQ-003 i_clock  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 i_wr  input  1  write strobe; one byte offered per cycle while high.
REQ-006 i_wr_data  input  DBIT  byte to enqueue, sampled with i_wr.
REQ-007 o_full  output  1  registered; high when count == DEPTH.
REQ-008 o_empty  output  1  registered; high when count == 0.
REQ-009 o_count  output  ADDR_BITS+1  registered number of stored bytes, 0..DEPTH.
REQ-010 o_overflow  output  1  dropped-write indication (see Configuration).
REQ-011 o_tx_start  output  1  registered one-cycle start pulse to the UART transmitter.
REQ-012 o_tx_data  output  DBIT  registered byte for the transmitter, stable from the o_tx_start cycle until the next launch.
REQ-013 i_tx_done_tick  input  1  one-cycle completion tick from the transmitter.
REQ-014 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 Write: i_wr high and o_full low at an edge SHALL store i_wr_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-016 Write with o_full high SHALL be dropped (storage, wr_ptr and count unchanged) and SHALL flag o_overflow.
REQ-017 Full test SHALL use the registered o_full only; a write coinciding with a pop while full is dropped.
REQ-018 FSM states: IDLE, WAIT_DONE.
REQ-019 IDLE with o_empty low at an edge: load o_tx_data from mem[rd_ptr], increment rd_ptr modulo DEPTH, set o_tx_start for exactly one cycle, go to WAIT_DONE.
REQ-020 IDLE with o_empty high: remain; o_tx_start stays 0.
REQ-021 WAIT_DONE: o_tx_start 0; on i_tx_done_tick go to IDLE; otherwise remain.
REQ-022 i_tx_done_tick in IDLE SHALL be ignored.
REQ-023 Latency: byte written at edge k into an empty idle FIFO SHALL produce o_tx_start high during the cycle after edge k+1.
REQ-024 Back-to-back: done tick at edge m with FIFO non-empty SHALL produce the next o_tx_start in the cycle after edge m+1.
REQ-025 Count: +1 on accepted write, -1 on pop, unchanged on simultaneous write and pop; never exceeds DEPTH or wraps below 0.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 without data corruption.

Reset
REQ-027 i_reset low SHALL immediately force: state IDLE, wr_ptr 0, rd_ptr 0, o_count 0, o_empty 1, o_full 0, o_overflow 0, o_tx_start 0, o_tx_data 0.
REQ-028 Reset mid-operation SHALL discard all queued bytes; memory contents are not reset.
REQ-029 After release, the first launch SHALL occur only after a new accepted write.

Configuration
REQ-030 Macro TX_FIFO_OVF_STICKY_EN defined: o_overflow SHALL set on first dropped write and hold 1 until reset.
REQ-031 Macro undefined: o_overflow SHALL be a registered one-cycle pulse per dropped write (high in the cycle after the dropped-write edge).

Verification
REQ-032 Reset, write 0x55 once -> o_tx_start high exactly one cycle after edge k+1, o_tx_data=0x55, o_busy=1, o_count back to 0.
REQ-033 Write 16 bytes 0x00..0x0F with no done ticks -> first launched, 15 remain; write 2 more -> one accepted, o_full=1, second dropped, o_overflow asserts.
REQ-034 Queue 0xA1,0xB2,0xC3, pulse i_tx_done_tick after each start -> three starts in order A1,B2,C3, each one cycle after edge following its done tick.
REQ-035 Fill, drain and refill across 40 bytes -> pointer wrap, order preserved, o_count never exceeds 16.
REQ-036 Assert i_reset low in WAIT_DONE with 5 bytes queued -> outputs at reset values immediately, no further o_tx_start after release until new write.
REQ-037 Run REQ-033 with and without TX_FIFO_OVF_STICKY_EN -> o_overflow held at 1 vs single-cycle pulse.

Source files
------------

// File: rtl/tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tx_fifo_feeder
//
// Byte FIFO in front of a UART transmitter. Producers push bytes with i_wr;
// a two-state launcher pops one byte whenever the transmitter is idle, presents
// it on o_tx_data with a one-cycle o_tx_start pulse, and waits for
// i_tx_done_tick before launching the next one.
//
// Build option:
//   TX_FIFO_OVF_STICKY_EN  defined   : o_overflow latches on the first dropped
//                                      write and holds until reset.
//                          undefined : o_overflow is a one-cycle pulse per
//                                      dropped write.
//
// Ports:
//   i_clock         in   clock, rising edge
//   i_reset         in   asynchronous reset, active low
//   i_wr            in   write strobe, one byte per cycle
//   i_wr_data       in   byte to enqueue
//   o_full          out  registered, count == DEPTH
//   o_empty         out  registered, count == 0
//   o_count         out  registered number of stored bytes (0..DEPTH)
//   o_overflow      out  dropped-write indication
//   o_tx_start      out  registered one-cycle launch pulse
//   o_tx_data       out  registered byte for the transmitter
//   i_tx_done_tick  in   completion tick from the transmitter
//   o_busy          out  launcher is waiting for a completion tick
// -----------------------------------------------------------------------------
module tx_fifo_feeder #(
  parameter int DBIT      = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DBIT-1:0]      i_wr_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_tx_start,
  output logic [DBIT-1:0]      o_tx_data,
  input  logic                 i_tx_done_tick,
  output logic                 o_busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } state_t;

  state_t               state, state_next;
  logic                 pop;
  logic                 wr_ok;
  logic                 dropped;
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count_next;
  logic [DBIT-1:0]      mem [DEPTH];

  // Full/empty are the registered flags, so a write arriving while full is
  // dropped even if a pop happens on the same edge.
  assign wr_ok   = i_wr & ~o_full;
  assign dropped = i_wr &  o_full;
  assign o_busy  = (state != IDLE);

  // ---------------------------------------------------------------- FSM
  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first, so no path through the case leaves an output
  // unassigned and infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        // Done ticks are ignored here; only a non-empty FIFO launches.
        if (!o_empty) begin
          pop        = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- count
  always_comb begin
    count_next = o_count;
    case ({wr_ok, pop})
      2'b10:   count_next = o_count + 1'b1;
      2'b01:   count_next = o_count - 1'b1;
      default: count_next = o_count;
    endcase
  end

  // ---------------------------------------------------------------- storage
  // NOTE: the array has no reset; clearing the pointers and count is what
  // discards queued bytes, and leaving the RAM unreset lets it map to memory.
  always_ff @(posedge i_clock) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      // Pointers are exactly ADDR_BITS wide, so +1 wraps DEPTH-1 -> 0.
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_tx_data <= mem[rd_ptr];
      end
      o_tx_start <= pop;
      o_count    <= count_next;
      o_empty    <= (count_next == '0);
      o_full     <= (count_next == DEPTH_CNT);
    end
  end

  // ---------------------------------------------------------------- overflow
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_overflow <= 1'b0;
    end else begin
`ifdef TX_FIFO_OVF_STICKY_EN
      if (dropped) o_overflow <= 1'b1;
`else
      o_overflow <= dropped;
`endif
    end
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tb_tx_fifo_feeder
//
// Directed bench for tx_fifo_feeder: reset values, single-byte latency, fill
// to full with overflow, in-order back-to-back launches, pointer wrap over a
// 40-byte fill/drain/refill, and reset in the middle of a transfer. Inputs
// change 1 time unit after the rising edge and outputs are sampled there.
// Follows TX_FIFO_OVF_STICKY_EN for the expected overflow behaviour.
// -----------------------------------------------------------------------------
module tb_tx_fifo_feeder;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_tx_done_tick = 1'b0;
  logic       o_full, o_empty, o_overflow, o_tx_start, o_busy;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;

  int checks = 0;
  int errors = 0;

`ifdef TX_FIFO_OVF_STICKY_EN
  localparam logic OVF_HELD = 1'b1;
`else
  localparam logic OVF_HELD = 1'b0;
`endif

  tx_fifo_feeder #(.DBIT(8), .ADDR_BITS(4)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_wr_data      (i_wr_data),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (i_tx_done_tick),
    .o_busy         (o_busy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    i_wr      = 1'b1;
    i_wr_data = d;
    tick();
    i_wr      = 1'b0;
  endtask

  task automatic do_reset();
    i_wr           = 1'b0;
    i_tx_done_tick = 1'b0;
    i_reset        = 1'b0;
    tick();
    tick();
    i_reset        = 1'b1;
  endtask

  // Write n consecutive bytes starting at base into an empty, idle FIFO.
  // The first byte launches on the second edge; count then trails by one.
  task automatic write_burst(input logic [7:0] base, input int n);
    for (int j = 1; j <= n; j++) begin
      wr_byte(8'(base + j - 1));
      check("burst_count", o_count, (j == 1) ? 1 : j - 1);
      check("burst_le16", (o_count <= 5'd16), 1);
      if (j == 2) begin
        check("burst_start", o_tx_start, 1);
        check("burst_data", o_tx_data, base);
      end
    end
  endtask

  // Done tick at edge m -> IDLE after m, launch visible after m+1.
  task automatic launch_next(input logic [7:0] exp);
    i_tx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
    check("ln_idle", o_busy, 0);
    check("ln_nostart", o_tx_start, 0);
    tick();
    check("ln_start", o_tx_start, 1);
    check("ln_data", o_tx_data, exp);
    check("ln_busy", o_busy, 1);
    check("ln_le16", (o_count <= 5'd16), 1);
  endtask

  task automatic drain(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) launch_next(8'(base + i));
  endtask

  task automatic finish_idle();
    i_tx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
    check("fi_busy", o_busy, 0);
    check("fi_empty", o_empty, 1);
    tick();
    check("fi_nostart", o_tx_start, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset values
    #1 i_reset = 1'b0;
    tick();
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_start", o_tx_start, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_busy", o_busy, 0);
    tick();
    i_reset = 1'b1;
    tick();
    check("idle_empty_nostart", o_tx_start, 0);

    // ---------------- single byte latency
    wr_byte(8'h55);
    check("w55_count", o_count, 1);
    check("w55_empty", o_empty, 0);
    check("w55_nostart", o_tx_start, 0);
    tick();
    check("w55_start", o_tx_start, 1);
    check("w55_data", o_tx_data, 8'h55);
    check("w55_busy", o_busy, 1);
    check("w55_count0", o_count, 0);
    check("w55_empty1", o_empty, 1);
    tick();
    check("w55_onecycle", o_tx_start, 0);
    check("w55_stillbusy", o_busy, 1);
    finish_idle();
    // done tick in IDLE is ignored
    i_tx_done_tick = 1'b1;
    tick();
    i_tx_done_tick = 1'b0;
    check("idle_tick_busy", o_busy, 0);
    check("idle_tick_start", o_tx_start, 0);

    // ---------------- fill to full, overflow
    do_reset();
    write_burst(8'h00, 16);
    check("f16_count", o_count, 15);
    check("f16_full", o_full, 0);
    check("f16_busy", o_busy, 1);
    wr_byte(8'h10);
    check("f17_count", o_count, 16);
    check("f17_full", o_full, 1);
    check("f17_ovf", o_overflow, 0);
    wr_byte(8'h11);
    check("f18_ovf", o_overflow, 1);
    check("f18_count", o_count, 16);
    check("f18_full", o_full, 1);
    tick();
    check("ovf_after1", o_overflow, OVF_HELD);
    check("ovf_count", o_count, 16);
    tick();
    check("ovf_after2", o_overflow, OVF_HELD);
    drain(8'h01, 16);
    finish_idle();
    check("ovf_drained", o_overflow, OVF_HELD);
    check("drained_count", o_count, 0);

    // ---------------- back-to-back ordered launches
    do_reset();
    check("b2b_ovf_clr", o_overflow, 0);
    wr_byte(8'hA1);
    check("b2b_c1", o_count, 1);
    wr_byte(8'hB2);
    check("b2b_s1", o_tx_start, 1);
    check("b2b_d1", o_tx_data, 8'hA1);
    wr_byte(8'hC3);
    check("b2b_s0", o_tx_start, 0);
    check("b2b_c2", o_count, 2);
    check("b2b_hold", o_tx_data, 8'hA1);
    launch_next(8'hB2);
    launch_next(8'hC3);
    finish_idle();

    // ---------------- 40 bytes: fill, drain, refill across the wrap
    do_reset();
    write_burst(8'h20, 17);
    check("wrap_full", o_full, 1);
    drain(8'h21, 16);
    finish_idle();
    write_burst(8'h31, 16);
    drain(8'h32, 15);
    finish_idle();
    write_burst(8'h41, 7);
    drain(8'h42, 6);
    finish_idle();

    // ---------------- reset while waiting with 5 bytes queued
    do_reset();
    write_burst(8'h60, 6);
    check("mid_count", o_count, 5);
    check("mid_busy", o_busy, 1);
    #2 i_reset = 1'b0;
    #1;
    check("mr_start", o_tx_start, 0);
    check("mr_data", o_tx_data, 0);
    check("mr_count", o_count, 0);
    check("mr_empty", o_empty, 1);
    check("mr_full", o_full, 0);
    check("mr_busy", o_busy, 0);
    check("mr_ovf", o_overflow, 0);
    tick();
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_tx_done_tick = k[0];
      tick();
      check("mr_nolaunch", o_tx_start, 0);
    end
    i_tx_done_tick = 1'b0;
    wr_byte(8'h77);
    check("mr_w_nostart", o_tx_start, 0);
    tick();
    check("mr_w_start", o_tx_start, 1);
    check("mr_w_data", o_tx_data, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
